dmem_access: RTL and testbench
==============================

DMEM_ACCESS -- requirements
Module: dmem_access

Interface
- REQ-001: Clock and reset are decided: one clock; reset is synchronous and active-high.
- REQ-002: Parameter MAX_WAIT, default 15: REQ-state cycles without mem_ack before a bus error.
- REQ-003: clk  in  1  sole clock; all state updates on its rising edge.
- REQ-004: reset  in  1  synchronous, active-high reset.
- REQ-005: MemRd  in  1  load request from the MEM-stage control decode.
- REQ-006: MemWr  in  1  store request from the MEM-stage control decode.
- REQ-007: Addr  in  32  byte address from the EX/MEM register.
- REQ-008: WrData  in  32  store data from the EX/MEM register.
- REQ-009: mem_req  out  1  data-memory request, registered.
- REQ-010: mem_we  out  1  1 = write, 0 = read; registered, valid with mem_req.
- REQ-011: mem_addr  out  32  registered address, valid with mem_req.
- REQ-012: mem_wdata  out  32  registered store data, valid with mem_req.
- REQ-013: mem_ack  in  1  memory completion strobe; sampled only in REQ.
- REQ-014: mem_rdata  in  32  read data, valid when mem_ack=1.
- REQ-015: RdData  out  32  load result to MEM/WB, registered.
- REQ-016: stall  out  1  freeze IF..MEM pipeline registers.
- REQ-017: bus_err  out  1  one-cycle pulse on timeout.
- REQ-018: align_err  out  1  one-cycle pulse on misaligned access; port always present.

Function
- REQ-019: FSM states are IDLE, REQ, DONE and ERR.
- REQ-020: IDLE with MemRd|MemWr goes to REQ; it captures Addr and WrData into mem_addr/mem_wdata, sets mem_we=MemWr and sets mem_req=1.
- REQ-021: When MemRd and MemWr are both 1, the access is a write.
- REQ-022: REQ with mem_ack=1 latches mem_rdata into RdData (reads only), clears mem_req and goes to DONE.
- REQ-023: REQ with mem_ack=0 increments the wait counter; when the counter equals MAX_WAIT-1 and mem_ack=0, clear mem_req, set RdData=0 and go to ERR.
- REQ-024: The wait counter clears on entry to REQ and is $clog2(MAX_WAIT+1) bits wide, with no wrap.
- REQ-025: DONE and ERR each last one cycle and return unconditionally to IDLE; no re-issue occurs even though MemRd/MemWr are still high.
- REQ-026: stall = (IDLE & (MemRd|MemWr)) | REQ, combinational; stall=0 in DONE and ERR so the pipeline advances at that edge.
- REQ-027: bus_err=1 only in ERR when entered by timeout.
- REQ-028: Minimum access latency is 3 cycles (IDLE detect, REQ with ack, DONE), i.e. 2 stall cycles.
- REQ-029: mem_ack outside REQ is ignored.
- REQ-030: RdData holds its value except when updated on an ack'd read or a timeout.

Reset
- REQ-031: Reset forces state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, RdData=0, bus_err=0 and align_err=0.
- REQ-032: Reset asserted in REQ drops mem_req at that edge; a late mem_ack is ignored.
- REQ-033: stall is 0 in the reset cycle; reset dominates all other inputs.

Configuration
- REQ-034: With DMEM_ALIGN_CHECK_EN defined, an access in IDLE with Addr[1:0]!=0 issues no request and goes to ERR with align_err=1, bus_err=0, RdData unchanged and stall=1 in the detect cycle.
- REQ-035: Without DMEM_ALIGN_CHECK_EN, align_err is tied to 0 and Addr passes to mem_addr unmodified.

Structure
- REQ-036: Shared package dmem_pkg holds the state encoding constants (IDLE=2'd0, REQ=2'd1, DONE=2'd2, ERR=2'd3) and the MAX_WAIT default.
- REQ-037: The wait counter is sub-module dmem_wait_cnt, with clear, enable and a terminal-count output.

Verification
- REQ-038: Load Addr=0x10, ack on the first REQ cycle with rdata=0xDEADBEEF -> stall high 2 cycles, RdData=0xDEADBEEF in DONE, mem_req high exactly 1 cycle.
- REQ-039: Store Addr=0x20, WrData=0x12345678, ack after 3 REQ cycles -> mem_we=1, mem_wdata=0x12345678, stall high 5 cycles, RdData unchanged.
- REQ-040: Load with no ack, MAX_WAIT=15 -> mem_req high 15 cycles, then ERR with bus_err pulse, RdData=0, stall=0.
- REQ-041: Reset asserted on the 2nd REQ cycle, then ack one cycle later -> mem_req=0 after the edge, state IDLE, RdData=0, no DONE.
- REQ-042: MemRd=MemWr=1 with ack -> write issued (mem_we=1).
- REQ-043: With DMEM_ALIGN_CHECK_EN, load Addr=0x13 -> no mem_req, align_err pulse, 2-cycle access; without the macro -> normal access to mem_addr=0x13.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: FSM state encoding
// and the default bus-timeout length.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/dmem_wait_cnt.sv
// Saturating wait counter for the REQ phase; tc flags the last allowed cycle
// before the access is declared a bus error.
module dmem_wait_cnt
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tc
);

   localparam int W = $clog2(MAX_WAIT + 1);

   logic [W-1:0] cnt;

   // Saturates at MAX_WAIT instead of wrapping, so a stuck enable cannot
   // bring tc back around.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && cnt != W'(MAX_WAIT)) begin
         cnt <= cnt + W'(1);
      end
   end

   assign tc = (cnt == W'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data-memory access controller: issues one registered request per
// load/store, stalls the pipeline until ack or timeout.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects word-misaligned accesses.
module dmem_access
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [31:0] Addr,
   input  logic [31:0] WrData,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] RdData,
   output logic        stall,
   output logic        bus_err,
   output logic        align_err
);

   state_t state;
   logic   access;
   logic   misaligned;
   logic   wait_tc;

   assign access = MemRd | MemWr;

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = (Addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Reset dominates: the pipeline must not be held while the core is reset.
   assign stall = !reset && ((state == IDLE && access) || state == REQ);

   dmem_wait_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (state != REQ),
      .en    (state == REQ && !mem_ack),
      .tc    (wait_tc)
   );

   // NOTE: state and every registered output use non-blocking assignments so
   // all of them update together at the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         RdData    <= '0;
         bus_err   <= 1'b0;
         align_err <= 1'b0;
      end else begin
         bus_err   <= 1'b0;
         align_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (access) begin
                  if (misaligned) begin
                     align_err <= 1'b1;
                     state     <= ERR;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= MemWr;
                     mem_addr  <= Addr;
                     mem_wdata <= WrData;
                     state     <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  if (!mem_we) RdData <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= DONE;
               end else if (wait_tc) begin
                  mem_req <= 1'b0;
                  RdData  <= '0;
                  bus_err <= 1'b1;
                  state   <= ERR;
               end
            end
            DONE, ERR: state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: expected outcomes are queued when an access is
// launched and compared when the controller finishes it (DONE/ERR cycle).
module tb_dmem_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRd, MemWr;
   logic [31:0] Addr, WrData;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] RdData;
   logic        stall, bus_err, align_err;

   typedef struct {
      logic [31:0] rd;
      logic        bus;
      logic        align;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_rd;
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   dmem_access dut (
      .clk       (clk),
      .reset     (reset),
      .MemRd     (MemRd),
      .MemWr     (MemWr),
      .Addr      (Addr),
      .WrData    (WrData),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .RdData    (RdData),
      .stall     (stall),
      .bus_err   (bus_err),
      .align_err (align_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // One complete access: ack_cycle is the REQ cycle (1-based) carrying
   // mem_ack, 0 means the memory never answers.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_cycle,
                         input logic [31:0] rdat, input int exp_stall,
                         input int exp_req, input logic exp_bus,
                         input logic exp_align, input string tag);
      exp_t e;
      int   n_stall = 0;
      int   n_req   = 0;
      bit   done    = 0;
      e.bus   = exp_bus;
      e.align = exp_align;
      if (exp_bus)               e.rd = 32'h0;
      else if (exp_align || wr)  e.rd = model_rd;
      else                       e.rd = rdat;
      exp_q.push_back(e);

      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         MemRd     = rd;
         MemWr     = wr;
         Addr      = a;
         WrData    = wd;
         mem_ack   = mem_req && (ack_cycle != 0) && (n_req + 1 == ack_cycle);
         mem_rdata = mem_ack ? rdat : $urandom;
         #1;
         if (mem_req) begin
            n_req++;
            if (n_req == 1) begin
               check({tag, ".mem_we"},    32'(mem_we), 32'(wr));
               check({tag, ".mem_addr"},  mem_addr,    a);
               check({tag, ".mem_wdata"}, mem_wdata,   wd);
            end
         end
         if (stall) n_stall++;
         else       done = 1;
      end
      check({tag, ".finished"}, 32'(done), 32'd1);

      e = exp_q.pop_front();
      check({tag, ".RdData"},    RdData,          e.rd);
      check({tag, ".bus_err"},   32'(bus_err),    32'(e.bus));
      check({tag, ".align_err"}, 32'(align_err),  32'(e.align));
      check({tag, ".stall_cyc"}, 32'(n_stall),    32'(exp_stall));
      check({tag, ".req_cyc"},   32'(n_req),      32'(exp_req));
      model_rd = e.rd;

      // Back in IDLE: error pulses gone, stray ack must not touch RdData.
      @(negedge clk);
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_1111;
      #1;
      check({tag, ".idle_stall"}, 32'(stall),     32'd0);
      check({tag, ".idle_err"},   32'({bus_err, align_err}), 32'd0);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check({tag, ".stray_ack"},  RdData,         model_rd);
   endtask

   initial begin
      reset     = 1'b1;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      Addr      = '0;
      WrData    = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      model_rd  = '0;

      // Reset values, and reset overriding a pending access request
      @(negedge clk);
      @(negedge clk);
      MemRd = 1'b1;
      mem_ack = 1'b1;
      #1;
      check("rst.stall",     32'(stall),   32'd0);
      check("rst.mem_req",   32'(mem_req), 32'd0);
      check("rst.mem_we",    32'(mem_we),  32'd0);
      check("rst.mem_addr",  mem_addr,     32'd0);
      check("rst.mem_wdata", mem_wdata,    32'd0);
      check("rst.RdData",    RdData,       32'd0);
      check("rst.errs",      32'({bus_err, align_err}), 32'd0);
      @(negedge clk);
      #1;
      check("rst.hold_req",  32'(mem_req), 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      MemRd   = 1'b0;
      mem_ack = 1'b0;

      access(1'b1, 1'b0, 32'h10, 32'h0,         1, 32'hDEAD_BEEF, 2,  1,  1'b0, 1'b0, "load");
      access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4, 32'h9999_9999, 5,  4,  1'b0, 1'b0, "store");
      access(1'b1, 1'b0, 32'h24, 32'h0,         0, 32'h0,         16, 15, 1'b1, 1'b0, "timeout");
      access(1'b1, 1'b0, 32'h30, 32'h0,         2, 32'hCAFE_F00D, 3,  2,  1'b0, 1'b0, "load2");

      // Reset on the 2nd REQ cycle, ack arriving one cycle later
      @(negedge clk);
      MemRd = 1'b1;
      Addr  = 32'h40;
      #1;
      check("rstreq.detect", 32'(stall), 32'd1);
      @(negedge clk);
      #1;
      check("rstreq.req1",   32'(mem_req), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstreq.stall",  32'(stall), 32'd0);
      @(negedge clk);
      reset     = 1'b0;
      MemRd     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_5555;
      #1;
      check("rstreq.mem_req", 32'(mem_req), 32'd0);
      check("rstreq.RdData",  RdData,       32'd0);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("rstreq.no_done", RdData,       32'd0);
      check("rstreq.idle",    32'(mem_req), 32'd0);
      model_rd = 32'h0;

      access(1'b1, 1'b1, 32'h44, 32'hA5A5_A5A5, 1, 32'h7777_7777, 2, 1, 1'b0, 1'b0, "rdwr");
`ifdef DMEM_ALIGN_CHECK_EN
      access(1'b1, 1'b0, 32'h13, 32'h0,         1, 32'h0BAD_F00D, 1, 0, 1'b0, 1'b1, "misalign");
`else
      access(1'b1, 1'b0, 32'h13, 32'h0,         1, 32'h0BAD_F00D, 2, 1, 1'b0, 1'b0, "misalign");
`endif

      check("sb.empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
